// File: rtl/pipe_output_credit_fifo.sv
// Credit-managed output FIFO that sits behind a fixed-latency pipeline with
// no backpressure. Upstream spends one credit per issued transfer, and each
// word popped downstream returns one credit. The storage is a circular buffer
// with first-word fall-through. A word that arrives while the FIFO is full
// and nothing is popping is dropped, and the sticky overflow flag records it.
//
// Handshake: the head word transfers on any cycle with out_vld && out_rdy.
// out_vld depends only on registered occupancy, and out_data holds steady
// while out_vld=1 and out_rdy=0. in_vld has no ready; each valid word is
// either accepted or dropped on the same edge.
module pipe_output_credit_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue,
  output logic                         can_issue,
  input  logic                         in_vld,
  input  logic [width-1:0]             in_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [width-1:0]             out_data,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] r_mem [depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_credits;
  logic             r_overflow;

  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_drop;
  logic             w_take;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rptr_nxt;

  // Transfer qualifiers and pointer wrap from depth-1 back to 0
  always_comb begin
    w_full     = (r_count == CW'(depth));
    w_pop      = (r_count != '0) && out_rdy;
    w_push     = in_vld && (!w_full || w_pop);
    w_drop     = in_vld && w_full && !w_pop;
    w_take     = issue && (r_credits != '0);
    w_wptr_nxt = (r_wptr == PW'(depth - 1)) ? '0 : r_wptr + PW'(1);
    w_rptr_nxt = (r_rptr == PW'(depth - 1)) ? '0 : r_rptr + PW'(1);
  end

  // Storage array is not reset because out_data only matters while out_vld=1
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  // Pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Credit counter: an issue spends a credit, a pop returns one, and the count is capped at depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CW'(depth);
    end else if (w_take && !w_pop) begin
      r_credits <= r_credits - CW'(1);
    end else if (w_pop && !w_take && (r_credits != CW'(depth))) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  // Outputs come from registered state only (fall-through head word)
  always_comb begin
    out_vld   = (r_count != '0);
    out_data  = r_mem[r_rptr];
    count     = r_count;
    overflow  = r_overflow;
    can_issue = (r_credits != '0);
  end

endmodule

// File: tb/tb_pipe_output_credit_fifo.sv
// Bench for pipe_output_credit_fifo (width=8, depth=4). The reference model is
// an ordered queue of accepted words, an integer credit count and an overflow bit.
module tb_pipe_output_credit_fifo;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         issue = 1'b0;
  logic         in_vld = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_rdy = 1'b0;
  logic         can_issue;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         overflow;

  logic [W-1:0] exp_q[$];
  int           exp_cred;
  logic         exp_ovf;
  int           n_vec = 0;
  int           n_err = 0;

  pipe_output_credit_fifo #(.width(W), .depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .can_issue(can_issue),
    .in_vld(in_vld), .in_data(in_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .count(count), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    exp_cred = D;
    exp_ovf  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; issue = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver: apply one cycle of inputs (left asserted afterwards) and advance the model
  task automatic step(input logic iss, input logic iv, input logic [W-1:0] d, input logic rdy);
    bit pop, push, take;
    issue = iss; in_vld = iv; in_data = d; out_rdy = rdy;
    pop  = (exp_q.size() != 0) && rdy;
    push = iv && ((exp_q.size() < D) || pop);
    take = iss && (exp_cred != 0);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(d);
    if (iv && !push) exp_ovf = 1'b1;
    exp_cred = exp_cred - int'(take) + int'(pop);
    if (exp_cred > D) exp_cred = D;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (can_issue !== 1'b1) begin n_err++; $display("FAIL reset_can_issue got %b exp 1", can_issue); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_latency();
    apply_reset();
    issue = 1'b0; in_vld = 1'b1; in_data = 8'h11; out_rdy = 1'b0;
    #1;
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL lat_no_bypass got %b exp 0", out_vld); end
    step(1'b0, 1'b1, 8'h11, 1'b0);
    n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL lat_one_cycle got %b exp 1", out_vld); end
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (out_data !== 8'h11) begin n_err++; $display("FAIL lat_head got %h exp 11", out_data); end
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL lat_count got %0d exp 3", count); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hA0 + W'(i), 1'b0);
    step(1'b0, 1'b1, 8'hA4, 1'b0);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d exp 4", count); end
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = 8'hA0 + W'(i);
      n_vec++; if (out_vld !== 1'b1 || out_data !== e) begin
        n_err++; $display("FAIL ovf_drain[%0d] got vld=%b data=%h exp vld=1 data=%h", i, out_vld, out_data, e);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b exp 0", out_vld); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    n_vec++; if (can_issue !== 1'b1) begin n_err++; $display("FAIL ovf_credit_cap got %b exp 1", can_issue); end
  endtask

  task automatic test_full_pass();
    logic [W-1:0] e;
    apply_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'hB0 + W'(i), 1'b0);
    step(1'b0, 1'b1, 8'hB5, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_ovf got %b exp 0", overflow); end
    for (int i = 2; i <= 5; i++) begin
      e = 8'hB0 + W'(i);
      n_vec++; if (out_vld !== 1'b1 || out_data !== e) begin
        n_err++; $display("FAIL full_drain[%0d] got vld=%b data=%h exp vld=1 data=%h", i, out_vld, out_data, e);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL full_empty got %b exp 0", out_vld); end
  endtask

  task automatic test_credits();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i < 4), 8'hC0 + W'(i), 1'b0);
      n_vec++; if (can_issue !== (exp_cred != 0)) begin
        n_err++; $display("FAIL cred_issue[%0d] got %b exp %b", i, can_issue, (exp_cred != 0));
      end
    end
    n_vec++; if (can_issue !== 1'b0) begin n_err++; $display("FAIL cred_exhausted got %b exp 0", can_issue); end
    step(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (can_issue !== 1'b1) begin n_err++; $display("FAIL cred_return got %b exp 1", can_issue); end
    step(1'b1, 1'b0, '0, 1'b1);
    n_vec++; if (can_issue !== 1'b1) begin n_err++; $display("FAIL cred_both got %b exp 1", can_issue); end
    step(1'b1, 1'b0, '0, 1'b0);
    n_vec++; if (can_issue !== 1'b0) begin n_err++; $display("FAIL cred_last got %b exp 0", can_issue); end
    n_vec++; if (count !== 3'(exp_q.size())) begin n_err++; $display("FAIL cred_count got %0d exp %0d", count, exp_q.size()); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL cred_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b1, 1'b1, 8'hD1, 1'b0);
    step(1'b1, 1'b1, 8'hD2, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    n_vec++; if (count !== 3'd2 || can_issue !== 1'b1) begin
      n_err++; $display("FAIL arst_pre got count=%0d can=%b exp count=2 can=1", count, can_issue);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_vld !== 1'b0 || count !== 3'd0 || can_issue !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL arst_immediate got vld=%b count=%0d can=%b ovf=%b exp 0/0/1/0", out_vld, count, can_issue, overflow);
    end
    issue = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic         iss, iv, rdy;
    logic [W-1:0] d;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      iss = 1'($urandom_range(0, 1));
      iv  = ($urandom_range(0, 99) < 55);
      rdy = ($urandom_range(0, 99) < 45);
      d   = W'($urandom);
      step(iss, iv, d, rdy);
      n_vec++; if (count !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, exp_q.size()); end
      n_vec++; if (out_vld !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_vld[%0d] got %b exp %b", i, out_vld, (exp_q.size() != 0)); end
      if (exp_q.size() != 0) begin
        n_vec++; if (out_data !== exp_q[0]) begin n_err++; $display("FAIL rnd_data[%0d] got %h exp %h", i, out_data, exp_q[0]); end
      end
      n_vec++; if (can_issue !== (exp_cred != 0)) begin n_err++; $display("FAIL rnd_can[%0d] got %b exp %b", i, can_issue, (exp_cred != 0)); end
      n_vec++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d] got %b exp %b", i, overflow, exp_ovf); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_overflow();
    test_full_pass();
    test_credits();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_output_credit_fifo.md
PIPE_OUTPUT_CREDIT_FIFO -- requirements
Module: pipe_output_credit_fifo

Interface
REQ-001 Parameter width, default 8, sets the data word width in bits.
REQ-002 Parameter depth, default 8, sets the number of FIFO entries and the initial credit count; legal range depth >= 2, power of two not required.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 issue  input  1  upstream launches one transfer into the fixed-latency valid pipeline this cycle.
REQ-006 can_issue  output  1  upstream may launch a transfer this cycle (credit available).
REQ-007 in_vld  input  1  pipeline output word valid this cycle; no backpressure path exists.
REQ-008 in_data  input  width  pipeline output word, qualified by in_vld.
REQ-009 out_vld  output  1  FIFO head word valid.
REQ-010 out_rdy  input  1  downstream accepts the head word.
REQ-011 out_data  output  width  FIFO head word, qualified by out_vld.
REQ-012 count  output  $clog2(depth+1)  current FIFO occupancy, 0..depth.
REQ-013 overflow  output  1  sticky error flag: a valid input word was dropped.

Function
REQ-014 pop SHALL be defined as out_vld && out_rdy; push SHALL be in_vld && (count < depth || pop).
REQ-015 Storage SHALL be a circular buffer with write and read pointers that wrap from depth-1 to 0.
REQ-016 On push, in_data SHALL be written at the write pointer on the clock edge; the write pointer advances by one.
REQ-017 On pop, the read pointer SHALL advance by one on the clock edge.
REQ-018 count SHALL increment on push without pop, decrement on pop without push, and stay unchanged on both or neither.
REQ-019 out_vld SHALL equal (count != 0); out_data SHALL present the entry at the read pointer combinationally (first-word fall-through).
REQ-020 Latency from in_vld to out_vld with an empty FIFO SHALL be exactly one cycle; no same-cycle bypass from in_data to out_data.
REQ-021 When full, in_vld with a simultaneous pop SHALL be accepted (no loss, count stays depth).
REQ-022 When full, in_vld without pop SHALL drop the word, leave FIFO contents and pointers unchanged, and set overflow on the next edge.
REQ-023 overflow SHALL remain 1 until reset.
REQ-024 out_vld=0 with out_rdy=1 SHALL have no effect.
REQ-025 A credit counter, range 0..depth, SHALL reset to depth.
REQ-026 can_issue SHALL equal (credits != 0), derived from registered state only.
REQ-027 issue && can_issue SHALL decrement credits; pop SHALL increment credits; both in one cycle SHALL leave credits unchanged.
REQ-028 issue while can_issue=0 SHALL be ignored (credits unchanged, overflow unaffected).
REQ-029 Invariant under correct upstream use: credits + count + in-flight transfers = depth; the block SHALL never increment credits above depth.
REQ-030 out_data SHALL be stable while out_vld=1 and out_rdy=0.

Reset
REQ-031 rst_n low SHALL asynchronously force count=0, read/write pointers=0, credits=depth, overflow=0, hence out_vld=0, can_issue=1.
REQ-032 Storage array contents SHALL NOT be reset; out_data is don't-care while out_vld=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words and outstanding credits immediately; release SHALL be synchronous-safe (first update on the first posedge after rst_n rises).

Verification (width=8, depth=4)
REQ-034 Reset then idle -> out_vld=0, count=0, can_issue=1, overflow=0.
REQ-035 in_vld with data 0x11,0x22,0x33 on consecutive cycles, out_rdy=0 -> out_vld rises one cycle after first in_vld, out_data=0x11, count=3.
REQ-036 Fill with 0xA0..0xA3, then in_vld 0xA4 with out_rdy=0 -> overflow=1, count=4; drain with out_rdy=1 -> outputs 0xA0,0xA1,0xA2,0xA3 in order, then out_vld=0; overflow stays 1.
REQ-037 Full FIFO, in_vld 0xB5 with out_rdy=1 same cycle -> count stays 4, overflow stays 0, 0xB5 emerges last in order.
REQ-038 issue held high 6 cycles, no pops -> can_issue drops after 4 accepted issues, credits=0; one pop -> can_issue=1 next cycle; issue+pop same cycle -> credits unchanged.
REQ-039 Assert rst_n low between clock edges with count=2, credits=1 -> out_vld=0, count=0, can_issue=1 immediately, before the next posedge.
